io_load_ctrl: RTL and testbench

IO_LOAD_CTRL -- requirements
Module: io_load_ctrl

---
 rtl/io_ctrl_pkg.sv | 27 ++
 rtl/region_counter.sv | 38 +++
 rtl/io_load_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_io_load_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// io_ctrl_pkg
// Shared definitions for the GPU load/process controller:
//   - default geometry (address width, region capacity, image base address)
//   - region select encoding (matches the GPU's cnn strobe: 1 = CNN region)
//   - controller state encoding
// ---------------------------------------------------------------------------
package io_ctrl_pkg;

    localparam int ADDR_W_DEF       = 12;
    localparam int REGION_WORDS_DEF = 2048;
    localparam int IMG_BASE_DEF     = 2048;

    localparam logic REGION_CNN = 1'b1;
    localparam logic REGION_IMG = 1'b0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_ACK,
        S_GAP,
        S_DECIDE,
        S_PROCESS,
        S_WAIT_ACC
    } state_t;

endpackage

// File: rtl/region_counter.sv
// ---------------------------------------------------------------------------
// region_counter
// Word counter for one memory region. Clears on request, increments by one
// per accepted write and saturates at LIMIT; full flags that saturation.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   clr          clear count to zero (has priority over inc)
//   inc          count one accepted word
//   count [CW]   current word count
//   full         count == LIMIT, no room for another word
// ---------------------------------------------------------------------------
module region_counter #(
    parameter int CW    = 13,
    parameter int LIMIT = 2048
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          full
);

    assign full = (count == CW'(LIMIT));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !full) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/io_load_ctrl.sv
// ---------------------------------------------------------------------------
// io_load_ctrl
// Accepts GPU words one at a time and writes them into either the CNN region
// (base 0) or the image region (base IMG_BASE) of a shared memory, then on a
// process command starts the accelerator and returns its 4-bit result.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   interrupt, load, cnn     GPU command strobe, load/process select, region
//   data [16]                GPU word
//   done                     one-cycle pulse: word consumed
//   datain [4], result_valid classification result and its valid level
//   mem_we/addr/wdata/ack    write request, held until mem_ack
//   acc_start, acc_*_words   accelerator start pulse and region word counts
//   acc_done, acc_result     accelerator completion and result
//   err_ovf                  sticky region-overflow flag
// ---------------------------------------------------------------------------
module io_load_ctrl
    import io_ctrl_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int REGION_WORDS = REGION_WORDS_DEF,
    parameter int IMG_BASE     = IMG_BASE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              interrupt,
    input  logic              load,
    input  logic              cnn,
    input  logic [15:0]       data,
    output logic              done,
    output logic [3:0]        datain,
    output logic              result_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              acc_start,
    output logic [ADDR_W-1:0] acc_cnn_words,
    output logic [ADDR_W-1:0] acc_img_words,
    input  logic              acc_done,
    input  logic [3:0]        acc_result,
    output logic              err_ovf
);

    localparam int CW = ADDR_W + 1;

    state_t          state;
    logic            region;
    logic            irq_pend;
    logic            pend_load;
    logic            pend_cnn;

    logic [CW-1:0]   cnn_count;
    logic [CW-1:0]   img_count;
    logic            cnn_full;
    logic            img_full;

    logic            cmd_seen;
    logic            cmd_load;
    logic            cmd_cnn;
    logic            restart;
    logic            go_process;
    logic            clr_cnn;
    logic            clr_img;
    logic            inc_cnn;
    logic            inc_img;
    logic [CW-1:0]   cur_count;
    logic            cur_full;

    function automatic logic [ADDR_W-1:0] word_addr(input logic sel,
                                                    input logic [ADDR_W-1:0] cnt);
        logic [ADDR_W-1:0] base;
        base = (sel == REGION_CNN) ? '0 : ADDR_W'(IMG_BASE);
        return base + cnt;
    endfunction

    function automatic logic [ADDR_W-1:0] sat_words(input logic [CW-1:0] cnt);
        return cnt[ADDR_W] ? '1 : cnt[ADDR_W-1:0];
    endfunction

    // Command decode. In DECIDE a live strobe wins over the pended one, so
    // the GPU's most recent load/cnn selection is what gets acted on.
    // NOTE: every always_comb output gets a default first so no path leaves
    // a signal unassigned, which would infer a latch.
    always_comb begin
        cmd_seen = 1'b0;
        cmd_load = load;
        cmd_cnn  = cnn;
        case (state)
            S_IDLE:   cmd_seen = interrupt;
            S_DECIDE: begin
                cmd_seen = interrupt | irq_pend;
                if (!interrupt) begin
                    cmd_load = pend_load;
                    cmd_cnn  = pend_cnn;
                end
            end
            default:  cmd_seen = 1'b0;
        endcase
        restart    = cmd_seen & cmd_load;
        go_process = cmd_seen & ~cmd_load;
        clr_cnn    = restart & (cmd_cnn == REGION_CNN);
        clr_img    = restart & (cmd_cnn == REGION_IMG);
        inc_cnn    = (state == S_WRITE) & mem_ack & (region == REGION_CNN);
        inc_img    = (state == S_WRITE) & mem_ack & (region == REGION_IMG);
        cur_count  = (region == REGION_CNN) ? cnn_count : img_count;
        cur_full   = (region == REGION_CNN) ? cnn_full  : img_full;
    end

    region_counter #(.CW(CW), .LIMIT(REGION_WORDS)) u_cnn_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_cnn),
        .inc   (inc_cnn),
        .count (cnn_count),
        .full  (cnn_full)
    );

    region_counter #(.CW(CW), .LIMIT(REGION_WORDS)) u_img_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_img),
        .inc   (inc_img),
        .count (img_count),
        .full  (img_full)
    );

    // Counts change only while loading, and a load always starts by clearing
    // its region, so the accelerator sees stable counts between restarts.
    assign acc_cnn_words = sat_words(cnn_count);
    assign acc_img_words = sat_words(img_count);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            done         <= 1'b0;
            mem_we       <= 1'b0;
            acc_start    <= 1'b0;
            result_valid <= 1'b0;
            err_ovf      <= 1'b0;
            datain       <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            irq_pend     <= 1'b0;
            pend_load    <= 1'b0;
            pend_cnn     <= 1'b0;
            region       <= REGION_IMG;
        end else begin
            done      <= 1'b0;
            acc_start <= 1'b0;

            case (state)
                S_IDLE, S_DECIDE: begin
                    if (restart) begin
                        // Counter clears on this same edge, so the first word
                        // of a load always goes to the region base.
                        region    <= cmd_cnn;
                        err_ovf   <= 1'b0;
                        mem_we    <= 1'b1;
                        mem_addr  <= word_addr(cmd_cnn, '0);
                        mem_wdata <= data;
                        state     <= S_WRITE;
                    end else if (go_process) begin
                        acc_start    <= 1'b1;
                        result_valid <= 1'b0;
                        state        <= S_PROCESS;
                    end else if (state == S_DECIDE) begin
                        if (cur_full) begin
                            // Region is full: drop the word but still hand
                            // the GPU its done so it keeps moving.
                            err_ovf <= 1'b1;
                            done    <= 1'b1;
                            state   <= S_ACK;
                        end else begin
                            mem_we    <= 1'b1;
                            mem_addr  <= word_addr(region, cur_count[ADDR_W-1:0]);
                            mem_wdata <= data;
                            state     <= S_WRITE;
                        end
                    end
                    if (state == S_DECIDE) begin
                        irq_pend <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        mem_we <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_ACK;
                    end
                end
                S_ACK:     state <= S_GAP;
                S_GAP:     state <= S_DECIDE;
                S_PROCESS: state <= S_WAIT_ACC;
                S_WAIT_ACC: begin
                    if (acc_done) begin
                        datain       <= acc_result;
                        result_valid <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                default:   state <= S_IDLE;
            endcase

            // A strobe arriving mid-word cannot be acted on yet; remember it
            // for DECIDE. WAIT_ACC deliberately does not pend.
            if (interrupt && (state == S_WRITE || state == S_ACK || state == S_GAP)) begin
                irq_pend  <= 1'b1;
                pend_load <= load;
                pend_cnn  <= cnn;
            end
        end
    end

endmodule

// File: tb/tb_io_load_ctrl.sv
// ---------------------------------------------------------------------------
// tb_io_load_ctrl
// Directed bench for io_load_ctrl. Each table record describes one load of
// N words followed by a process command, with hand-computed expectations.
// A small GPU/memory responder inside tick() presents the next word after
// every done, raises the follow-up command right after the last done, and
// acknowledges writes after a configurable delay. The DUT uses
// REGION_WORDS = 4 so region overflow is reachable in a few words.
// ---------------------------------------------------------------------------
module tb_io_load_ctrl;

    localparam int ADDR_W = 12;

    typedef struct {
        bit          cnn;
        int          nwords;
        logic [15:0] w0;
        logic [15:0] step;
        int          dly;
        int          exp_writes;
        int          exp_done;
        bit          exp_ovf;
        int          base;
        int          exp_cnn;
        int          exp_img;
        logic [3:0]  res;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              interrupt;
    logic              load;
    logic              cnn;
    logic [15:0]       data;
    logic              done;
    logic [3:0]        datain;
    logic              result_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_ack;
    logic              acc_start;
    logic [ADDR_W-1:0] acc_cnn_words;
    logic [ADDR_W-1:0] acc_img_words;
    logic              acc_done;
    logic [3:0]        acc_result;
    logic              err_ovf;

    io_load_ctrl #(.ADDR_W(ADDR_W), .REGION_WORDS(4), .IMG_BASE(2048)) dut (
        .clk           (clk),
        .rst           (rst),
        .interrupt     (interrupt),
        .load          (load),
        .cnn           (cnn),
        .data          (data),
        .done          (done),
        .datain        (datain),
        .result_valid  (result_valid),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .acc_start     (acc_start),
        .acc_cnn_words (acc_cnn_words),
        .acc_img_words (acc_img_words),
        .acc_done      (acc_done),
        .acc_result    (acc_result),
        .err_ovf       (err_ovf)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // responder / observation state
    int                cyc = 0;
    int                done_cnt, start_cnt, we_any;
    int                ack_delay, we_cycles, ack_cyc;
    bit                ack_valid;
    logic [ADDR_W-1:0] hold_addr;
    logic [15:0]       hold_wdata;
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [15:0]       wr_data_q[$];
    logic [15:0]       words[$];
    int                widx;
    bit                tail_pend, tail_load, tail_cnn;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: sample #1 after the rising edge, then drive the GPU and
    // memory responses for the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        interrupt = 1'b0;
        if (done) begin
            done_cnt++;
            if (ack_valid) begin
                check("done_one_cycle_after_ack", cyc, ack_cyc + 1);
                ack_valid = 1'b0;
            end
            widx++;
            if (widx < words.size()) begin
                data = words[widx];
            end else if (tail_pend) begin
                interrupt = 1'b1;
                load      = tail_load;
                cnn       = tail_cnn;
                tail_pend = 1'b0;
            end
        end
        if (acc_start) start_cnt++;
        if (mem_we) begin
            we_any++;
            check("done_low_while_we", done, 0);
            if (we_cycles == 0) begin
                hold_addr  = mem_addr;
                hold_wdata = mem_wdata;
            end else begin
                check("mem_addr_stable", mem_addr, hold_addr);
                check("mem_wdata_stable", mem_wdata, hold_wdata);
            end
            we_cycles++;
            if (we_cycles > ack_delay) begin
                mem_ack = 1'b1;
                wr_addr_q.push_back(mem_addr);
                wr_data_q.push_back(mem_wdata);
                ack_cyc   = cyc;
                ack_valid = 1'b1;
            end
        end else begin
            if (we_cycles != 0) check("mem_we_high_cycles", we_cycles, ack_delay + 1);
            we_cycles = 0;
            mem_ack   = 1'b0;
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int budget;
        words.delete();
        for (int i = 0; i < v.nwords; i++) words.push_back(v.w0 + 16'(i) * v.step);
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cnt  = 0;
        start_cnt = 0;
        ack_delay = v.dly;
        widx      = 0;
        tail_pend = 1'b1;
        tail_load = 1'b0;
        tail_cnn  = 1'b0;
        data      = words[0];
        load      = 1'b1;
        cnn       = v.cnn;
        interrupt = 1'b1;
        budget    = 0;
        while (start_cnt == 0 && budget < 400) begin
            tick();
            budget++;
        end
        check($sformatf("v%0d acc_start_seen", id), start_cnt, 1);
        check($sformatf("v%0d result_valid_cleared", id), result_valid, 0);
        check($sformatf("v%0d acc_cnn_words", id), acc_cnn_words, v.exp_cnn);
        check($sformatf("v%0d acc_img_words", id), acc_img_words, v.exp_img);
        repeat (10) tick();
        acc_result = v.res;
        acc_done   = 1'b1;
        tick();
        acc_done   = 1'b0;
        check($sformatf("v%0d datain", id), datain, v.res);
        check($sformatf("v%0d result_valid", id), result_valid, 1);
        check($sformatf("v%0d done_pulses", id), done_cnt, v.exp_done);
        check($sformatf("v%0d mem_writes", id), wr_addr_q.size(), v.exp_writes);
        check($sformatf("v%0d err_ovf", id), err_ovf, v.exp_ovf);
        check($sformatf("v%0d acc_start_pulses", id), start_cnt, 1);
        for (int i = 0; i < wr_addr_q.size() && i < v.exp_writes; i++) begin
            check($sformatf("v%0d wr%0d addr", id, i), wr_addr_q[i], v.base + i);
            check($sformatf("v%0d wr%0d data", id, i), wr_data_q[i], words[i]);
        end
        tick();
    endtask

    initial begin
        int budget;
        //          cnn  n  w0        step      dly wr dn ovf base  cnn img res
        vecs[0] = '{1'b1, 2, 16'hA5A5, 16'h6C8F, 1,  2, 2, 1'b0, 0,    2, 0, 4'h3};
        vecs[1] = '{1'b0, 3, 16'h0100, 16'h0001, 1,  3, 3, 1'b0, 2048, 2, 3, 4'h7};
        vecs[2] = '{1'b1, 5, 16'hBEEF, 16'h0003, 2,  4, 5, 1'b1, 0,    4, 3, 4'hC};
        vecs[3] = '{1'b0, 1, 16'h5555, 16'h0000, 3,  1, 1, 1'b0, 2048, 4, 1, 4'h1};
        vecs[4] = '{1'b0, 4, 16'hF000, 16'h0101, 0,  4, 4, 1'b0, 2048, 4, 4, 4'hF};
        vecs[5] = '{1'b1, 2, 16'h0F0F, 16'h1010, 8,  2, 2, 1'b0, 0,    2, 4, 4'h9};
        vecs[6] = '{1'b1, 1, 16'h7777, 16'h0000, 1,  1, 1, 1'b0, 0,    1, 0, 4'h2};

        rst = 1'b0; interrupt = 1'b0; load = 1'b0; cnn = 1'b0; data = '0;
        mem_ack = 1'b0; acc_done = 1'b0; acc_result = '0;
        we_cycles = 0; ack_valid = 1'b0; ack_delay = 1; widx = 0; tail_pend = 1'b0;
        done_cnt = 0; start_cnt = 0; we_any = 0;
        repeat (3) tick();
        check("rst done", done, 0);
        check("rst mem_we", mem_we, 0);
        check("rst acc_start", acc_start, 0);
        check("rst result_valid", result_valid, 0);
        check("rst err_ovf", err_ovf, 0);
        check("rst datain", datain, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst mem_wdata", mem_wdata, 0);
        check("rst acc_cnn_words", acc_cnn_words, 0);
        check("rst acc_img_words", acc_img_words, 0);
        rst = 1'b1;
        tick();

        for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

        // Load strobe during WAIT_ACC must be ignored.
        wr_addr_q.delete(); wr_data_q.delete();
        we_any = 0; start_cnt = 0; words.delete(); widx = 0; tail_pend = 1'b0;
        load = 1'b0; cnn = 1'b0; interrupt = 1'b1;
        budget = 0;
        while (start_cnt == 0 && budget < 20) begin
            tick();
            budget++;
        end
        check("wacc acc_start_seen", start_cnt, 1);
        tick();
        load = 1'b1; cnn = 1'b1; data = 16'hDEAD; interrupt = 1'b1;
        repeat (5) tick();
        acc_result = 4'h5; acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
        check("wacc datain", datain, 4'h5);
        check("wacc result_valid", result_valid, 1);
        repeat (6) tick();
        check("wacc no_mem_we", we_any, 0);
        check("wacc acc_cnn_words_kept", acc_cnn_words, 2);
        check("wacc acc_start_pulses", start_cnt, 1);

        // Reset while a write is outstanding.
        words.delete(); words.push_back(16'h4444); widx = 0; tail_pend = 1'b0;
        ack_delay = 1000; we_any = 0;
        load = 1'b1; cnn = 1'b0; data = 16'h4444; interrupt = 1'b1;
        budget = 0;
        while (we_any == 0 && budget < 20) begin
            tick();
            budget++;
        end
        check("rmw mem_we_raised", we_any, 1);
        repeat (2) tick();
        #2 rst = 1'b0;
        #1;
        check("rmw mem_we_dropped", mem_we, 0);
        check("rmw done", done, 0);
        check("rmw mem_addr", mem_addr, 0);
        check("rmw acc_cnn_words", acc_cnn_words, 0);
        check("rmw acc_img_words", acc_img_words, 0);
        check("rmw err_ovf", err_ovf, 0);
        we_cycles = 0; mem_ack = 1'b0; ack_valid = 1'b0; interrupt = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        run_vec(vecs[6], 6);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
